// File: rtl/otp_pkg.sv
// Shared types and constants for the OTP display session controller.
// The optional LEADING_ZERO_BLANK_EN build uses blank_leading() at digit commit.
package otp_pkg;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        CONVERT,
        SHOW
    } otp_state_t;

    localparam int BCD_W      = 4;
    localparam int NUM_DIGITS = 5;
    localparam int HASH_W     = 16;
    localparam int DIGITS_W   = BCD_W * NUM_DIGITS;

    localparam logic [BCD_W-1:0] BLANK_CODE = 4'hF;

    // Replaces zero digits from the most significant end with BLANK_CODE; the units digit is kept.
    function automatic logic [DIGITS_W-1:0] blank_leading(input logic [DIGITS_W-1:0] digits);
        logic [DIGITS_W-1:0] result;
        logic                leading;
        result  = digits;
        leading = 1'b1;
        for (int i = NUM_DIGITS - 1; i > 0; i--) begin
            if (leading && (digits[i*BCD_W +: BCD_W] == '0)) begin
                result[i*BCD_W +: BCD_W] = BLANK_CODE;
            end else begin
                leading = 1'b0;
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/bcd_dabble_seq.sv
// Serial double-dabble: one add-3/shift step per sysclk, 16 steps per conversion.
// `done` and `bcd` present the result of the step taken on the current edge.
module bcd_dabble_seq
    import otp_pkg::*;
(
    input  logic                sysclk,
    input  logic                rst_n,
    input  logic                start,
    input  logic [HASH_W-1:0]   bin,
    output logic                done,
    output logic [DIGITS_W-1:0] bcd
);

    localparam logic [4:0] LAST_STEP = 5'(HASH_W - 1);

    logic [HASH_W-1:0]   r_bin;
    logic [DIGITS_W-1:0] r_bcd;
    logic [4:0]          r_step;
    logic                r_active;

    logic [DIGITS_W-1:0] w_adj;
    logic [DIGITS_W-1:0] w_shift;

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        w_adj = r_bcd;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (r_bcd[i*BCD_W +: BCD_W] >= 4'd5) begin
                w_adj[i*BCD_W +: BCD_W] = r_bcd[i*BCD_W +: BCD_W] + 4'd3;
            end
        end
        w_shift = {w_adj[DIGITS_W-2:0], r_bin[HASH_W-1]};
    end

    // Combinational so the parent can commit all digits on the very edge of the final shift.
    assign done = r_active && (r_step == LAST_STEP);
    assign bcd  = w_shift;

    // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
    always_ff @(posedge sysclk or negedge rst_n) begin
        if (!rst_n) begin
            r_bin    <= '0;
            r_bcd    <= '0;
            r_step   <= '0;
            r_active <= 1'b0;
        end else if (start) begin
            r_bin    <= bin;
            r_bcd    <= '0;
            r_step   <= '0;
            r_active <= 1'b1;
        end else if (r_active) begin
            r_bcd  <= w_shift;
            r_bin  <= {r_bin[HASH_W-2:0], 1'b0};
            r_step <= r_step + 5'd1;
            if (r_step == LAST_STEP) begin
                r_active <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/otp_session_ctrl.sv
// Button debounce, timed display session and scheduled hash-to-BCD conversion.
// Define LEADING_ZERO_BLANK_EN to output leading zero digits as the blank code.
module otp_session_ctrl
    import otp_pkg::*;
#(
    parameter int DEBOUNCE_TICKS = 4,
    parameter int SHOW_PERIODS   = 3
) (
    input  logic              sysclk,
    input  logic              rst_n,
    input  logic              tick_500hz,
    input  logic              tick_5s,
    input  logic              button_in,
    input  logic [HASH_W-1:0] hash_in,
    output logic [BCD_W-1:0]  D5_out,
    output logic [BCD_W-1:0]  D4_out,
    output logic [BCD_W-1:0]  D3_out,
    output logic [BCD_W-1:0]  D2_out,
    output logic [BCD_W-1:0]  D1_out,
    output logic              display_en,
    output logic              busy
);

    localparam int              DB_W         = (DEBOUNCE_TICKS > 1) ? $clog2(DEBOUNCE_TICKS) : 1;
    localparam logic [DB_W-1:0] DB_LAST      = DB_W'(DEBOUNCE_TICKS - 1);
    localparam logic [3:0]      COUNT_RELOAD = 4'(SHOW_PERIODS);

    logic [1:0]          r_sync;
    logic                r_db_state;
    logic [DB_W-1:0]     r_db_cnt;
    logic                r_press;

    otp_state_t          r_state;
    logic [3:0]          r_count;
    logic                r_pending;
    logic                r_busy;
    logic                r_display_en;
    logic [DIGITS_W-1:0] r_digits;

    logic                w_start;
    logic                w_done;
    logic [DIGITS_W-1:0] w_bcd;
    logic [DIGITS_W-1:0] w_commit;

    always_ff @(posedge sysclk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[0], button_in};
        end
    end

    // The counter tracks consecutive samples that disagree with the accepted level.
    always_ff @(posedge sysclk or negedge rst_n) begin
        if (!rst_n) begin
            r_db_state <= 1'b0;
            r_db_cnt   <= '0;
            r_press    <= 1'b0;
        end else begin
            r_press <= 1'b0;
            if (tick_500hz) begin
                if (r_sync[1] == r_db_state) begin
                    r_db_cnt <= '0;
                end else if (r_db_cnt == DB_LAST) begin
                    r_db_state <= r_sync[1];
                    r_db_cnt   <= '0;
                    r_press    <= r_sync[1];
                end else begin
                    r_db_cnt <= r_db_cnt + 1'b1;
                end
            end
        end
    end

    assign w_start = (r_state == LOAD);

    bcd_dabble_seq u_dabble (
        .sysclk (sysclk),
        .rst_n  (rst_n),
        .start  (w_start),
        .bin    (hash_in),
        .done   (w_done),
        .bcd    (w_bcd)
    );

`ifdef LEADING_ZERO_BLANK_EN
    assign w_commit = blank_leading(w_bcd);
`else
    assign w_commit = w_bcd;
`endif

    // A tick_5s seen during LOAD/CONVERT is held in r_pending and replayed as one reconversion.
    always_ff @(posedge sysclk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= IDLE;
            r_count      <= '0;
            r_pending    <= 1'b0;
            r_busy       <= 1'b0;
            r_display_en <= 1'b0;
            r_digits     <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (r_press) begin
                        r_count <= COUNT_RELOAD;
                        r_state <= LOAD;
                    end
                end
                LOAD: begin
                    r_busy    <= 1'b1;
                    r_pending <= tick_5s;
                    if (r_press) begin
                        r_count <= COUNT_RELOAD;
                    end
                    r_state <= CONVERT;
                end
                CONVERT: begin
                    if (r_press) begin
                        r_count <= COUNT_RELOAD;
                    end
                    if (tick_5s) begin
                        r_pending <= 1'b1;
                    end
                    if (w_done) begin
                        r_digits     <= w_commit;
                        r_busy       <= 1'b0;
                        r_display_en <= 1'b1;
                        r_state      <= (r_pending || tick_5s) ? LOAD : SHOW;
                    end
                end
                SHOW: begin
                    if (r_press) begin
                        r_count <= COUNT_RELOAD;
                        if (tick_5s) begin
                            r_state <= LOAD;
                        end
                    end else if (tick_5s) begin
                        if (r_count <= 4'd1) begin
                            r_count      <= '0;
                            r_display_en <= 1'b0;
                            r_digits     <= '0;
                            r_state      <= IDLE;
                        end else begin
                            r_count <= r_count - 4'd1;
                            r_state <= LOAD;
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign D5_out     = r_digits[4*BCD_W +: BCD_W];
    assign D4_out     = r_digits[3*BCD_W +: BCD_W];
    assign D3_out     = r_digits[2*BCD_W +: BCD_W];
    assign D2_out     = r_digits[1*BCD_W +: BCD_W];
    assign D1_out     = r_digits[0 +: BCD_W];
    assign display_en = r_display_en;
    assign busy       = r_busy;

endmodule

// File: tb/tb_otp_session_ctrl.sv
// Scoreboard bench for otp_session_ctrl: stimulus pushes expected digit updates,
// a negedge monitor pops and compares them on every commit or session close.
module tb_otp_session_ctrl;

    logic        sysclk;
    logic        rst_n;
    logic        tick_500hz;
    logic        tick_5s;
    logic        button_in;
    logic [15:0] hash_in;
    logic [3:0]  D5_out, D4_out, D3_out, D2_out, D1_out;
    logic        display_en;
    logic        busy;

    typedef struct {
        logic [19:0] dig;
        logic        en;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks;
    int   n_errors;

    wire [19:0] dig = {D5_out, D4_out, D3_out, D2_out, D1_out};

    otp_session_ctrl #(
        .DEBOUNCE_TICKS (4),
        .SHOW_PERIODS   (3)
    ) dut (
        .sysclk     (sysclk),
        .rst_n      (rst_n),
        .tick_500hz (tick_500hz),
        .tick_5s    (tick_5s),
        .button_in  (button_in),
        .hash_in    (hash_in),
        .D5_out     (D5_out),
        .D4_out     (D4_out),
        .D3_out     (D3_out),
        .D2_out     (D2_out),
        .D1_out     (D1_out),
        .display_en (display_en),
        .busy       (busy)
    );

    initial sysclk = 1'b0;
    always #5 sysclk = ~sysclk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Hand-written BCD expectations; the blank build shows leading zeros as F.
    function automatic logic [19:0] exp_dig(input logic [19:0] plain);
        logic [19:0] r;
        r = plain;
`ifdef LEADING_ZERO_BLANK_EN
        for (int i = 4; i > 0; i--) begin
            if (r[i*4 +: 4] != 4'h0) break;
            r[i*4 +: 4] = 4'hF;
        end
`endif
        return r;
    endfunction

    task automatic push_exp(input logic [19:0] d, input logic en);
        exp_t e;
        e.dig = d;
        e.en  = en;
        exp_q.push_back(e);
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge sysclk);
        #1;
    endtask

    task automatic pulse_db();
        tick_500hz = 1'b1;
        cyc(1);
        tick_500hz = 1'b0;
        cyc(1);
    endtask

    task automatic pulse_5s();
        tick_5s = 1'b1;
        cyc(1);
        tick_5s = 1'b0;
    endtask

    task automatic press_hold();
        button_in = 1'b1;
        cyc(3);
        repeat (4) pulse_db();
    endtask

    task automatic release_btn();
        button_in = 1'b0;
        cyc(3);
        repeat (4) pulse_db();
    endtask

    task automatic wait_commit();
        int n;
        n = 0;
        while (busy !== 1'b1 && n < 60) begin
            cyc(1);
            n++;
        end
        while (busy === 1'b1 && n < 60) begin
            cyc(1);
            n++;
        end
        if (n >= 60) begin
            n_checks++;
            n_errors++;
            $display("FAIL commit_timeout: busy did not complete within %0d cycles", n);
        end
        cyc(2);
    endtask

    // Monitor: digits may only move on a commit (busy falling) or a session close.
    initial begin
        logic        prev_busy;
        logic        prev_en;
        logic [19:0] prev_dig;
        int          busy_len;
        logic        commit;
        logic        close;
        exp_t        e;
        prev_busy = 1'b0;
        prev_en   = 1'b0;
        prev_dig  = '0;
        busy_len  = 0;
        forever begin
            @(negedge sysclk);
            if (rst_n !== 1'b1) begin
                prev_busy = 1'b0;
                prev_en   = 1'b0;
                prev_dig  = dig;
                busy_len  = 0;
            end else begin
                commit = prev_busy && !busy;
                close  = prev_en && !display_en;
                if (commit || close) begin
                    if (exp_q.size() == 0) begin
                        check("scoreboard_has_entry", 32'(exp_q.size()), 32'd1);
                    end else begin
                        e = exp_q.pop_front();
                        check("digits", {12'h0, dig}, {12'h0, e.dig});
                        check("display_en", {31'h0, display_en}, {31'h0, e.en});
                    end
                    if (commit) check("busy_len", busy_len, 16);
                end else if (dig !== prev_dig) begin
                    check("atomic_digits", {12'h0, dig}, {12'h0, prev_dig});
                end
                busy_len  = busy ? busy_len + 1 : 0;
                prev_busy = busy;
                prev_en   = display_en;
                prev_dig  = dig;
            end
        end
    end

    initial begin
        n_checks   = 0;
        n_errors   = 0;
        rst_n      = 1'b0;
        tick_500hz = 1'b0;
        tick_5s    = 1'b0;
        button_in  = 1'b0;
        hash_in    = 16'h0000;
        cyc(3);
        check("reset_digits", {12'h0, dig}, 32'h0);
        check("reset_display_en", {31'h0, display_en}, 32'h0);
        check("reset_busy", {31'h0, busy}, 32'h0);
        rst_n = 1'b1;
        cyc(2);

        // Bounce of two samples must not open a session.
        button_in = 1'b1;
        cyc(3);
        repeat (2) pulse_db();
        button_in = 1'b0;
        cyc(3);
        repeat (4) pulse_db();
        cyc(20);
        check("bounce_display_en", {31'h0, display_en}, 32'h0);
        check("bounce_busy", {31'h0, busy}, 32'h0);

        // 0xFFFF with exact press-to-digit latency.
        hash_in = 16'hFFFF;
        push_exp(exp_dig(20'h65535), 1'b1);
        button_in = 1'b1;
        cyc(3);
        repeat (3) pulse_db();
        tick_500hz = 1'b1;
        cyc(1);
        tick_500hz = 1'b0;
        cyc(1);
        check("latency_busy_in_load", {31'h0, busy}, 32'h0);
        cyc(1);
        check("latency_busy_rise", {31'h0, busy}, 32'h1);
        cyc(15);
        check("latency_busy_last", {31'h0, busy}, 32'h1);
        check("latency_en_before", {31'h0, display_en}, 32'h0);
        cyc(1);
        check("latency_digits", {12'h0, dig}, {12'h0, exp_dig(20'h65535)});
        check("latency_en_after", {31'h0, display_en}, 32'h1);
        release_btn();
        cyc(5);

        // Periodic re-sample, new hash held back until completion, pending tick merge.
        push_exp(exp_dig(20'h65535), 1'b1);
        pulse_5s();
        wait_commit();
        hash_in = 16'h3039;
        push_exp(exp_dig(20'h12345), 1'b1);
        push_exp(exp_dig(20'h12345), 1'b1);
        pulse_5s();
        cyc(8);
        check("hold_old_digits", {12'h0, dig}, {12'h0, exp_dig(20'h65535)});
        check("busy_mid_convert", {31'h0, busy}, 32'h1);
        pulse_5s();
        cyc(2);
        pulse_5s();
        wait_commit();
        wait_commit();
        push_exp(20'h00000, 1'b0);
        pulse_5s();
        cyc(3);
        check("close_display_en", {31'h0, display_en}, 32'h0);
        check("close_digits", {12'h0, dig}, 32'h0);

        // Zero hash from a fresh session.
        hash_in = 16'h0000;
        push_exp(exp_dig(20'h00000), 1'b1);
        press_hold();
        wait_commit();
        release_btn();

        // Press coinciding with tick_5s reloads the count and still reconverts.
        hash_in = 16'd42;
        push_exp(exp_dig(20'h00042), 1'b1);
        pulse_5s();
        wait_commit();
        hash_in = 16'd99;
        push_exp(exp_dig(20'h00099), 1'b1);
        button_in = 1'b1;
        cyc(3);
        repeat (3) pulse_db();
        tick_500hz = 1'b1;
        cyc(1);
        tick_500hz = 1'b0;
        tick_5s    = 1'b1;
        cyc(1);
        tick_5s = 1'b0;
        wait_commit();
        release_btn();
        hash_in = 16'd7;
        push_exp(exp_dig(20'h00007), 1'b1);
        pulse_5s();
        wait_commit();
        push_exp(exp_dig(20'h00007), 1'b1);
        pulse_5s();
        wait_commit();
        check("reload_kept_open", {31'h0, display_en}, 32'h1);
        push_exp(20'h00000, 1'b0);
        pulse_5s();
        cyc(3);
        check("reload_close_en", {31'h0, display_en}, 32'h0);

        // Asynchronous reset in the middle of a reconversion.
        hash_in = 16'd1234;
        push_exp(exp_dig(20'h01234), 1'b1);
        press_hold();
        wait_commit();
        release_btn();
        hash_in = 16'd5555;
        pulse_5s();
        cyc(6);
        check("pre_reset_busy", {31'h0, busy}, 32'h1);
        #2 rst_n = 1'b0;
        #1;
        check("async_reset_digits", {12'h0, dig}, 32'h0);
        check("async_reset_en", {31'h0, display_en}, 32'h0);
        check("async_reset_busy", {31'h0, busy}, 32'h0);
        exp_q.delete();
        cyc(3);
        rst_n = 1'b1;
        cyc(5);
        check("post_reset_idle_en", {31'h0, display_en}, 32'h0);
        check("post_reset_idle_busy", {31'h0, busy}, 32'h0);
        hash_in = 16'd54321;
        push_exp(exp_dig(20'h54321), 1'b1);
        press_hold();
        wait_commit();
        release_btn();
        cyc(4);

        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
